// File: rtl/rv151_bpu_pkg.sv
// Shared types and constants for the rv151 branch predictor / redirect controller.
package rv151_bpu_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RDR  = 1'b1
  } bpu_st_e;

  localparam logic [1:0] CNT_SN = 2'b00;
  localparam logic [1:0] CNT_WN = 2'b01;
  localparam logic [1:0] CNT_WT = 2'b10;
  localparam logic [1:0] CNT_ST = 2'b11;

  function automatic logic [1:0] sat_upd(input logic [1:0] cnt, input logic tk);
    logic [1:0] nxt;
    nxt = cnt;
    if (tk) begin
      if (cnt != CNT_ST) nxt = cnt + 2'd1;
    end else begin
      if (cnt != CNT_SN) nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rv151_bpu_bht.sv
// Branch history table: 2-bit saturating counters with a registered MSB read port.
module rv151_bpu_bht
  import rv151_bpu_pkg::*;
#(
  parameter int unsigned IDX_W = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_msb,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_tk
);

  localparam int unsigned N = 1 << IDX_W;

  logic [1:0] cnt_q [N];
  logic [1:0] cnt_d [N];
  logic       rd_msb_q, rd_msb_d;

  // Read uses the pre-update array so a same-cycle write to the same entry returns the old value.
  always_comb begin
    rd_msb_d = rd_en ? cnt_q[rd_idx][1] : rd_msb_q;
    for (int unsigned i = 0; i < N; i++) cnt_d[i] = cnt_q[i];
    if (wr_en) cnt_d[wr_idx] = sat_upd(cnt_q[wr_idx], wr_tk);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < N; i++) cnt_q[i] <= CNT_WN;
      rd_msb_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
      rd_msb_q <= rd_msb_d;
    end
  end

  assign rd_msb = rd_msb_q;

endmodule

// File: rtl/rv151_bpu.sv
// Branch prediction and redirect controller: BHT lookup, EX-side training,
// mispredict redirect/flush handshake and branch/mispredict perf counters.
module rv151_bpu
  import rv151_bpu_pkg::*;
#(
  parameter int unsigned BHT_IDX_W = 6,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             lk_vld,
  input  logic [31:0]      lk_pc,
  output logic             pd_vld,
  output logic             pd_tk,
  input  logic             rs_vld,
  input  logic [31:0]      rs_pc,
  input  logic             rs_pred_tk,
  input  logic             rs_tk,
  input  logic [31:0]      rs_tgt,
  output logic             rdr_vld,
  output logic [31:0]      rdr_pc,
  input  logic             rdr_rdy,
  output logic             flush,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mp_cnt
);

  bpu_st_e            state_q, state_d;
  logic [31:0]        rdr_pc_q, rdr_pc_d;
  logic               pd_vld_q, pd_vld_d;
  logic [CNT_W-1:0]   br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]   mp_cnt_q, mp_cnt_d;
  logic               accept, mispred;

  rv151_bpu_bht #(.IDX_W(BHT_IDX_W)) u_bht (
    .clk    (clk),
    .rstn   (rstn),
    .rd_en  (lk_vld),
    .rd_idx (lk_pc[BHT_IDX_W+1:2]),
    .rd_msb (pd_tk),
    .wr_en  (accept),
    .wr_idx (rs_pc[BHT_IDX_W+1:2]),
    .wr_tk  (rs_tk)
  );

  // Resolves seen while redirecting are wrong-path and must not train or count.
  assign accept  = rs_vld && (state_q == ST_IDLE);
  assign mispred = accept && (rs_tk != rs_pred_tk);

  always_comb begin
    state_d  = state_q;
    rdr_pc_d = rdr_pc_q;
    pd_vld_d = lk_vld;
    unique case (state_q)
      ST_IDLE: begin
        if (mispred) begin
          state_d  = ST_RDR;
          rdr_pc_d = rs_tk ? rs_tgt : rs_pc + 32'd4;
        end
      end
      ST_RDR: begin
        if (rdr_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (cnt_clr) begin
      br_cnt_d = '0;
      mp_cnt_d = '0;
    end else begin
      if (accept && (br_cnt_q != '1)) br_cnt_d = br_cnt_q + 1'b1;
      if (mispred && (mp_cnt_q != '1)) mp_cnt_d = mp_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      rdr_pc_q <= '0;
      pd_vld_q <= 1'b0;
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rdr_pc_q <= rdr_pc_d;
      pd_vld_q <= pd_vld_d;
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign pd_vld  = pd_vld_q;
  assign rdr_vld = (state_q == ST_RDR);
  assign flush   = rdr_vld;
  assign rdr_pc  = rdr_pc_q;
  assign br_cnt  = br_cnt_q;
  assign mp_cnt  = mp_cnt_q;

endmodule

// File: tb/tb_rv151_bpu.sv
// Self-checking bench for rv151_bpu: directed scenarios plus randomized traffic
// checked against a behavioural model of the predictor, FSM and counters.
module tb_rv151_bpu;

  localparam int unsigned IDX_W = 6;
  localparam int unsigned CW    = 4;
  localparam int unsigned CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rstn, lk_vld, rs_vld, rs_pred_tk, rs_tk, rdr_rdy, cnt_clr;
  logic [31:0]   lk_pc, rs_pc, rs_tgt;
  logic          pd_vld, pd_tk, rdr_vld, flush;
  logic [31:0]   rdr_pc;
  logic [CW-1:0] br_cnt, mp_cnt;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  // Behavioural model state
  int unsigned bht [1 << IDX_W];
  bit          m_rdr, m_pdv, m_pdt;
  logic [31:0] m_rdr_pc;
  int unsigned m_br, m_mp;

  always #5 clk = ~clk;

  rv151_bpu #(.BHT_IDX_W(IDX_W), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .lk_vld(lk_vld), .lk_pc(lk_pc), .pd_vld(pd_vld), .pd_tk(pd_tk),
    .rs_vld(rs_vld), .rs_pc(rs_pc), .rs_pred_tk(rs_pred_tk), .rs_tk(rs_tk), .rs_tgt(rs_tgt),
    .rdr_vld(rdr_vld), .rdr_pc(rdr_pc), .rdr_rdy(rdr_rdy), .flush(flush),
    .cnt_clr(cnt_clr), .br_cnt(br_cnt), .mp_cnt(mp_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc >> 2) % (1 << IDX_W);
  endfunction

  task automatic model_reset();
    foreach (bht[i]) bht[i] = 1;
    m_rdr = 0; m_pdv = 0; m_pdt = 0; m_rdr_pc = 0; m_br = 0; m_mp = 0;
  endtask

  task automatic model_step();
    bit acc, mis;
    if (!rstn) begin
      model_reset();
      return;
    end
    m_pdv = lk_vld;
    if (lk_vld) m_pdt = (bht[idx_of(lk_pc)] >= 2);
    acc = rs_vld && !m_rdr;
    mis = acc && (rs_tk != rs_pred_tk);
    if (acc) begin
      if (rs_tk) bht[idx_of(rs_pc)] = (bht[idx_of(rs_pc)] == 3) ? 3 : bht[idx_of(rs_pc)] + 1;
      else       bht[idx_of(rs_pc)] = (bht[idx_of(rs_pc)] == 0) ? 0 : bht[idx_of(rs_pc)] - 1;
    end
    if (m_rdr) begin
      if (rdr_rdy) m_rdr = 0;
    end else if (mis) begin
      m_rdr    = 1;
      m_rdr_pc = rs_tk ? rs_tgt : rs_pc + 32'd4;
    end
    if (cnt_clr) begin
      m_br = 0; m_mp = 0;
    end else begin
      if (acc && m_br < CMAX) m_br++;
      if (mis && m_mp < CMAX) m_mp++;
    end
  endtask

  task automatic cmp_all();
    chk("pd_vld", 32'(pd_vld), 32'(m_pdv));
    if (m_pdv) chk("pd_tk", 32'(pd_tk), 32'(m_pdt));
    chk("rdr_vld", 32'(rdr_vld), 32'(m_rdr));
    chk("flush", 32'(flush), 32'(m_rdr));
    chk("rdr_pc", rdr_pc, m_rdr_pc);
    chk("br_cnt", 32'(br_cnt), m_br);
    chk("mp_cnt", 32'(mp_cnt), m_mp);
  endtask

  // One clock: drive on the falling edge, update the model at the rising edge, check 1 time unit later.
  task automatic cyc(input bit rn, input bit lkv, input logic [31:0] lkpc,
                     input bit rsv, input logic [31:0] rspc, input bit prd, input bit tk,
                     input logic [31:0] tgt, input bit rdy, input bit clr);
    @(negedge clk);
    rstn = rn; lk_vld = lkv; lk_pc = lkpc; rs_vld = rsv; rs_pc = rspc;
    rs_pred_tk = prd; rs_tk = tk; rs_tgt = tgt; rdr_rdy = rdy; cnt_clr = clr;
    @(posedge clk);
    model_step();
    #1;
    cmp_all();
  endtask

  task automatic idle(input bit rdy);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, rdy, 0);
  endtask

  task automatic lookup(input logic [31:0] pc);
    cyc(1, 1, pc, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic resolve(input logic [31:0] pc, input bit prd, input bit tk, input logic [31:0] tgt);
    cyc(1, 0, 0, 1, pc, prd, tk, tgt, 0, 0);
  endtask

  logic [31:0] pcs [8] = '{32'h100, 32'h104, 32'h200, 32'h108, 32'hFFFF_FFFC, 32'h1100, 32'h10C, 32'h300};

  initial begin
    model_reset();
    rstn = 0; lk_vld = 0; lk_pc = 0; rs_vld = 0; rs_pc = 0;
    rs_pred_tk = 0; rs_tk = 0; rs_tgt = 0; rdr_rdy = 0; cnt_clr = 0;

    // 1: reset, then first lookup
    cyc(0, 1, 32'h100, 1, 32'h100, 0, 1, 32'h40, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_rdr_vld", 32'(rdr_vld), 0);
    chk("rst_br_cnt", 32'(br_cnt), 0);
    lookup(32'h100);
    chk("first_pd_vld", 32'(pd_vld), 1);
    chk("first_pd_tk", 32'(pd_tk), 0);

    // 2: training and saturation
    resolve(32'h100, 1, 1, 32'h40);
    resolve(32'h100, 1, 1, 32'h40);
    lookup(32'h100);
    chk("trained_tk", 32'(pd_tk), 1);
    resolve(32'h100, 1, 1, 32'h40);
    for (int i = 0; i < 4; i++) resolve(32'h100, 0, 0, 32'h40);
    lookup(32'h100);
    chk("trained_nt", 32'(pd_tk), 0);
    resolve(32'h100, 1, 1, 32'h40);
    lookup(32'h100);
    chk("floor_sat", 32'(pd_tk), 0);

    // 3: taken mispredict, stall, then accept
    resolve(32'h200, 0, 1, 32'h80);
    chk("mp_rdr_vld", 32'(rdr_vld), 1);
    chk("mp_rdr_pc", rdr_pc, 32'h80);
    for (int i = 0; i < 3; i++) idle(0);
    chk("hold_rdr_pc", rdr_pc, 32'h80);
    idle(1);
    chk("rel_rdr_vld", 32'(rdr_vld), 0);

    // 4: not-taken mispredict with PC wrap
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    resolve(32'hFFFF_FFFC, 1, 0, 32'h1234);
    chk("wrap_rdr_pc", rdr_pc, 32'h0);
    chk("wrap_mp_cnt", 32'(mp_cnt), 1);
    chk("wrap_br_cnt", 32'(br_cnt), 1);

    // 5: wrong-path resolves ignored; same-cycle lookup/update returns old value
    resolve(32'h104, 1, 1, 0);
    resolve(32'h104, 1, 1, 0);
    chk("rdr_br_cnt", 32'(br_cnt), 1);
    idle(1);
    lookup(32'h104);
    chk("rdr_no_train", 32'(pd_tk), 0);
    cyc(1, 1, 32'h104, 1, 32'h104, 1, 1, 0, 0, 0);
    chk("rw_old_val", 32'(pd_tk), 0);
    lookup(32'h104);
    chk("rw_new_val", 32'(pd_tk), 1);

    // 6: counter saturation, clear priority, reset during redirect
    for (int i = 0; i < 20; i++) resolve(32'h108, 0, 0, 0);
    chk("br_sat", 32'(br_cnt), CMAX);
    cyc(1, 0, 0, 1, 32'h10C, 0, 1, 32'h50, 0, 1);
    chk("clr_br", 32'(br_cnt), 0);
    chk("clr_mp", 32'(mp_cnt), 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_in_rdr", 32'(rdr_vld), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(99) != 0), $urandom_range(1), pcs[$urandom_range(7)],
          ($urandom_range(2) != 0), pcs[$urandom_range(7)], $urandom_range(1), $urandom_range(1),
          $urandom, ($urandom_range(3) == 0), ($urandom_range(49) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
